// File: rtl/multicycle_control.sv
// Multi-cycle datapath controller: Moore FSM sequencing fetch/decode/execute/writeback
// for a MIPS-like subset (R-type, lw, sw, beq, j, addi), with a sticky illegal-op trap.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  instr_op,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal_op,
    output logic [15:0] instr_count
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11,
        StError    = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write_uncond;
        logic       fetch;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    state_e      state_q, state_d;
    ctrl_t       ctrl_q;
    logic [15:0] instr_count_q, instr_count_d;
    logic        retire;

    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            StDecode: begin
                c.alu_src_b = 2'b11;
            end
            StMemAddr: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StMemRead: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            StMemWrite: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            StRExec: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            StRWb: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            StBranch: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            StJump: begin
                c.pc_write_uncond = 1'b1;
                c.pc_source       = 2'b10;
            end
            StAddiExec: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            StAddiWb: begin
                c.reg_write = 1'b1;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch: begin
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (instr_op)
                    OpRtype:    state_d = StRExec;
                    OpLw, OpSw: state_d = StMemAddr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiExec;
                    default:    state_d = StError;
                endcase
            end
            StMemAddr: begin
                if (instr_op == OpSw) begin
                    state_d = StMemWrite;
                end else if (instr_op == OpLw) begin
                    state_d = StMemRead;
                end else begin
                    state_d = StError;
                end
            end
            StMemRead: begin
                if (mem_ready) state_d = StMemWb;
            end
            StMemWrite: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StMemWb, StRWb, StBranch, StJump, StAddiWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StRExec:    state_d = StRWb;
            StAddiExec: state_d = StAddiWb;
            StError:    state_d = StError;
            default:    state_d = StError;
        endcase
    end

    assign instr_count_d = retire ? instr_count_q + 16'd1 : instr_count_q;

    // Control bits are registered as the decode of the next state, so they always
    // equal the decode of the current state without a combinational path from state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            ctrl_q        <= decode_ctrl(StFetch);
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= decode_ctrl(state_d);
            instr_count_q <= instr_count_d;
        end
    end

    // IR load and PC increment in FETCH fire only in the cycle the memory completes.
    assign ir_write      = ctrl_q.fetch & mem_ready;
    assign pc_write      = ctrl_q.pc_write_uncond | (ctrl_q.fetch & mem_ready);
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign iord          = ctrl_q.iord;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign pc_source     = ctrl_q.pc_source;
    assign alu_op        = ctrl_q.alu_op;
    assign illegal_op    = ctrl_q.illegal;
    assign state         = state_q;
    assign instr_count   = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of instruction state traces plus
// hand-written reset, trap and counter-wrap sequences, checked through a scoreboard queue.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  instr_op = 6'h3F;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, pc_source, alu_op;
    logic [3:0]  state;
    logic [15:0] instr_count;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk          (clk),
        .rst          (rst),
        .instr_op     (instr_op),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .iord         (iord),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_write     (ir_write),
        .mem_to_reg   (mem_to_reg),
        .reg_dst      (reg_dst),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .pc_source    (pc_source),
        .alu_op       (alu_op),
        .state        (state),
        .illegal_op   (illegal_op),
        .instr_count  (instr_count)
    );

    logic [16:0] act_ctrl;
    assign act_ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                       pc_source, illegal_op};

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
    } exp_t;

    // seq holds one state per nibble (index 0 in the low nibble); rdy holds mem_ready per cycle.
    typedef struct {
        logic [5:0]  op;
        logic [47:0] seq;
        logic [11:0] rdy;
        int          len;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] cnt_exp = 16'd0;

    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic       pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] srcb, aop, ps;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        srcb = 2'b00;
        aop  = 2'b00;
        ps   = 2'b00;
        case (st)
            4'd0:  begin mr = 1'b1; srcb = 2'b01; irw = rdy; pw = rdy; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin sa = 1'b1; srcb = 2'b10; end
            4'd3:  begin mr = 1'b1; io = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin mw = 1'b1; io = 1'b1; end
            4'd6:  begin sa = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rd = 1'b1; end
            4'd8:  begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; end
            4'd9:  begin pw = 1'b1; ps = 2'b10; end
            4'd10: begin sa = 1'b1; srcb = 2'b10; end
            4'd11: rw = 1'b1;
            4'd15: ill = 1'b1;
            default: ill = 1'b0;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, srcb, aop, ps, ill};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs, queue the expected outputs, compare, advance to next negedge.
    task automatic step(input logic [3:0] st, input logic rdy, input logic [5:0] op);
        exp_t e;
        mem_ready = rdy;
        instr_op  = op;
        sb.push_back({st, exp_ctrl(st, rdy)});
        #1;
        e = sb.pop_front();
        check("state", {28'd0, state}, {28'd0, e.st});
        check("ctrl", {15'd0, act_ctrl}, {15'd0, e.ctrl});
        @(negedge clk);
    endtask

    // instr_op carries the real opcode only where it is sampled; elsewhere it is junk.
    task automatic run_vec(input int idx);
        vec_t       v;
        logic [3:0] st;
        v = vecs[idx];
        for (int i = 0; i < v.len; i++) begin
            st = v.seq[4*i +: 4];
            step(st, v.rdy[i], (st == 4'd1 || st == 4'd2) ? v.op : 6'h3F);
        end
        cnt_exp++;
        check("instr_count", {16'd0, instr_count}, {16'd0, cnt_exp});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{op: 6'b000000, seq: 48'h7610,     rdy: 12'h00F, len: 4};
        vecs[1] = '{op: 6'b100011, seq: 48'h43210,    rdy: 12'h01F, len: 5};
        vecs[2] = '{op: 6'b101011, seq: 48'h5210,     rdy: 12'h009, len: 4};
        vecs[3] = '{op: 6'b000100, seq: 48'h810,      rdy: 12'h001, len: 3};
        vecs[4] = '{op: 6'b000010, seq: 48'h910,      rdy: 12'h007, len: 3};
        vecs[5] = '{op: 6'b001000, seq: 48'hBA10,     rdy: 12'h005, len: 4};
        vecs[6] = '{op: 6'b100011, seq: 48'h43333210, rdy: 12'h041, len: 8};
        vecs[7] = '{op: 6'b101011, seq: 48'h555210,   rdy: 12'h021, len: 6};
        vecs[8] = '{op: 6'b000000, seq: 48'h761000,   rdy: 12'h004, len: 6};
        vecs[9] = '{op: 6'b001000, seq: 48'hBA100,    rdy: 12'h002, len: 5};

        // Reset state, with and without a completing fetch.
        repeat (2) @(negedge clk);
        step(4'd0, 1'b0, 6'h3F);
        step(4'd0, 1'b1, 6'h3F);
        rst = 1'b0;
        check("reset_count", {16'd0, instr_count}, 32'd0);

        for (int v = 0; v < 10; v++) run_vec(v);

        // Illegal opcode traps in ERROR regardless of inputs until reset.
        step(4'd0, 1'b1, 6'h3F);
        step(4'd1, 1'b0, 6'h3F);
        for (int i = 0; i < 12; i++) begin
            step(4'd15, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        end
        check("error_count_hold", {16'd0, instr_count}, {16'd0, cnt_exp});
        rst = 1'b1;
        step(4'd15, 1'b1, 6'h00);
        rst = 1'b0;
        cnt_exp = 16'd0;
        step(4'd0, 1'b0, 6'h3F);
        check("error_reset_count", {16'd0, instr_count}, {16'd0, cnt_exp});

        // Reset wins over an illegal opcode in DECODE.
        run_vec(4);
        run_vec(4);
        step(4'd0, 1'b1, 6'h3F);
        rst = 1'b1;
        step(4'd1, 1'b0, 6'h3F);
        rst = 1'b0;
        cnt_exp = 16'd0;
        step(4'd0, 1'b0, 6'h3F);
        check("decode_reset_count", {16'd0, instr_count}, {16'd0, cnt_exp});

        // Reset wins over a completing store: no retire.
        run_vec(0);
        step(4'd0, 1'b1, 6'h3F);
        step(4'd1, 1'b0, 6'b101011);
        step(4'd2, 1'b1, 6'b101011);
        rst = 1'b1;
        step(4'd5, 1'b1, 6'h3F);
        rst = 1'b0;
        cnt_exp = 16'd0;
        step(4'd0, 1'b0, 6'h3F);
        check("sw_reset_count", {16'd0, instr_count}, {16'd0, cnt_exp});

        // Reset during a load memory wait.
        run_vec(1);
        step(4'd0, 1'b1, 6'h3F);
        step(4'd1, 1'b0, 6'b100011);
        step(4'd2, 1'b0, 6'b100011);
        step(4'd3, 1'b0, 6'h3F);
        rst = 1'b1;
        step(4'd3, 1'b0, 6'h3F);
        rst = 1'b0;
        cnt_exp = 16'd0;
        step(4'd0, 1'b0, 6'h3F);
        check("lw_reset_count", {16'd0, instr_count}, {16'd0, cnt_exp});

        // Counter wrap: preset near the top instead of retiring 65533 jumps.
        force dut.instr_count_q = 16'hFFFD;
        #1;
        release dut.instr_count_q;
        cnt_exp = 16'hFFFD;
        for (int i = 0; i < 4; i++) run_vec(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
